// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - shared types, default geometry and width helper for the flow window controller
package flow_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;
    localparam int DEF_WIN   = 3;

    // Bits needed to hold a coordinate 0..n-1, never less than one bit.
    function automatic int coord_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flow_xy_counter.sv
// rtl/flow_xy_counter.sv - raster x/y position counter with wrap, restart and last-pixel flag
// Ports: clk, reset (async, active-high); inc advances one pixel; clear restarts at (0,0)
//        and, together with inc, counts the restarted pixel as (0,0); x/y current position;
//        last high while the position is (W-1, H-1).
module flow_xy_counter
    import flow_pkg::*;
#(
    parameter int W = DEF_IMG_W,
    parameter int H = DEF_IMG_H
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    input  logic                   clear,
    output logic [coord_w(W)-1:0]  x,
    output logic [coord_w(H)-1:0]  y,
    output logic                   last
);

    localparam int XW = coord_w(W);
    localparam int YW = coord_w(H);

    logic [XW-1:0] x_q, x_d, base_x;
    logic [YW-1:0] y_q, y_d, base_y;

    always_comb begin
        base_x = clear ? '0 : x_q;
        base_y = clear ? '0 : y_q;
        x_d    = base_x;
        y_d    = base_y;
        if (inc) begin
            if (base_x == XW'(W - 1)) begin
                x_d = '0;
                y_d = (base_y == YW'(H - 1)) ? '0 : base_y + YW'(1);
            end else begin
                x_d = base_x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == XW'(W - 1)) && (y_q == YW'(H - 1));

endmodule

// File: rtl/flow_window_ctrl.sv
// rtl/flow_window_ctrl.sv - pixel-stream sequencer driving the line-buffer shift enable and window-valid flag
// Ports: clk, reset (async, active-high); pix_valid/pix_sof/pix_ready input pixel handshake;
//        shift_en flop-chain enable; win_valid/win_x/win_y window present and its centre;
//        out_ready compute-stage acceptance; frame_done one-cycle end-of-frame pulse;
//        busy while a frame is in progress.
// Optional macro FLOW_WIN_ERR_EN adds err_sticky (premature SOF or orphan pixel seen).
module flow_window_ctrl
    import flow_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int WIN   = DEF_WIN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    output logic                      pix_ready,
    output logic                      shift_en,
    output logic                      win_valid,
    output logic [coord_w(IMG_W)-1:0] win_x,
    output logic [coord_w(IMG_H)-1:0] win_y,
    input  logic                      out_ready,
    output logic                      frame_done,
`ifdef FLOW_WIN_ERR_EN
    output logic                      err_sticky,
`endif
    output logic                      busy
);

    localparam int XW   = coord_w(IMG_W);
    localparam int YW   = coord_w(IMG_H);
    localparam int EDGE = WIN - 1;
    localparam int HALF = (WIN - 1) / 2;

    state_t        state_q, state_d;
    logic          win_valid_q, win_valid_d;
    logic [XW-1:0] win_x_q, win_x_d, cnt_x, px;
    logic [YW-1:0] win_y_q, win_y_d, cnt_y, py;
    logic          frame_done_q, frame_done_d;
    logic          stall, accept, start, take, win_set, cnt_last;

    flow_xy_counter #(.W(IMG_W), .H(IMG_H)) u_xy (
        .clk   (clk),
        .reset (reset),
        .inc   (take),
        .clear (start),
        .x     (cnt_x),
        .y     (cnt_y),
        .last  (cnt_last)
    );

    always_comb begin
        stall     = win_valid_q & ~out_ready;
        // Backpressure only matters mid-frame; IDLE always drains the input.
        pix_ready = (state_q == IDLE) ? 1'b1 : ~stall;
        accept    = pix_valid & pix_ready;
        // SOF starts a frame from either state; a mid-frame SOF truncates the current one.
        start     = accept & pix_sof;
        take      = accept & (pix_sof | (state_q == ACTIVE));
        px        = start ? '0 : cnt_x;
        py        = start ? '0 : cnt_y;
        win_set   = take && (px >= XW'(EDGE)) && (py >= YW'(EDGE));

        state_d = state_q;
        if (start) begin
            state_d = ACTIVE;
        end else if (take && cnt_last) begin
            state_d = IDLE;
        end

        frame_done_d = take & ~pix_sof & cnt_last;
        win_valid_d  = win_set | (win_valid_q & ~out_ready);
        win_x_d      = win_set ? px - XW'(HALF) : win_x_q;
        win_y_d      = win_set ? py - YW'(HALF) : win_y_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef FLOW_WIN_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (accept &  pix_sof & (state_q == ACTIVE))
              | (accept & ~pix_sof & (state_q == IDLE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

    assign shift_en   = take;
    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_flow_window_ctrl.sv
// tb/tb_flow_window_ctrl.sv - self-checking bench for flow_window_ctrl with a window scoreboard
module tb_flow_window_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic       out_ready = 1'b1;
    logic       pix_ready, shift_en, win_valid, frame_done, busy;
    logic [1:0] win_x, win_y;
`ifdef FLOW_WIN_ERR_EN
    logic       err_sticky;
`endif

    always #5 clk = ~clk;

    flow_window_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .shift_en   (shift_en),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .out_ready  (out_ready),
        .frame_done (frame_done),
`ifdef FLOW_WIN_ERR_EN
        .err_sticky (err_sticky),
`endif
        .busy       (busy)
    );

    typedef struct {
        int x;
        int y;
    } win_t;

    int   total = 0;
    int   bad = 0;
    win_t sbq[$];
    int   fd_at[$];
    bit   m_active = 0;
    int   m_x = 0;
    int   m_y = 0;
    bit   m_fd = 0;
    bit   m_err = 0;
    int   acc_cnt = 0;
    int   dut_cons = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive after the falling edge, check handshake outputs, advance the
    // reference model at the rising edge, then check registered outputs.
    task automatic cyc(input logic v, input logic s, input logic r);
        bit exp_rdy, acc, take;
        int px, py;
        @(negedge clk);
        pix_valid = v;
        pix_sof   = s;
        out_ready = r;
        #1;
        exp_rdy = !m_active ? 1'b1 : !((sbq.size() != 0) && !r);
        acc     = v && exp_rdy;
        take    = acc && (m_active || s);
        chk("pix_ready", pix_ready, exp_rdy);
        chk("shift_en", shift_en, take);
        if (win_valid && r) dut_cons++;
        px = (s || !m_active) ? 0 : m_x;
        py = (s || !m_active) ? 0 : m_y;
        @(posedge clk);
        if ((sbq.size() != 0) && r) sbq.delete(0);
        if (acc && ((m_active && s) || (!m_active && !s))) m_err = 1;
        m_fd = take && m_active && !s && (px == W - 1) && (py == H - 1);
        if (take) begin
            acc_cnt++;
            if (px >= N - 1 && py >= N - 1) sbq.push_back('{px - (N - 1) / 2, py - (N - 1) / 2});
            m_active = !((px == W - 1) && (py == H - 1));
            m_x = px + 1;
            m_y = py;
            if (m_x == W) begin
                m_x = 0;
                m_y = (py + 1 == H) ? 0 : py + 1;
            end
        end
        #1;
        chk("win_valid", win_valid, sbq.size() != 0);
        if (sbq.size() != 0) begin
            chk("win_x", win_x, sbq[0].x);
            chk("win_y", win_y, sbq[0].y);
        end
        chk("frame_done", frame_done, m_fd);
        if (frame_done) fd_at.push_back(acc_cnt);
        chk("busy", busy, m_active);
`ifdef FLOW_WIN_ERR_EN
        chk("err_sticky", err_sticky, m_err);
`endif
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic reset_async();
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_win_x", win_x, 0);
        chk("rst_win_y", win_y, 0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_shift_en", shift_en, 1'b0);
`ifdef FLOW_WIN_ERR_EN
        chk("rst_err_sticky", err_sticky, 1'b0);
`endif
        m_active = 0;
        m_x = 0;
        m_y = 0;
        m_fd = 0;
        m_err = 0;
        sbq.delete();
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        // Reset state
        reset_async();
        cyc(1'b0, 1'b0, 1'b1);

        // 1: single frame, no backpressure
        fd_at.delete();
        for (int i = 0; i < W * H; i++) cyc(1'b1, i == 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t1_frame_done_count", fd_at.size(), 1);

        // 2: compute stage holds off after the first window
        for (int i = 0; i < 11; i++) cyc(1'b1, i == 0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // 3: orphan pixels while idle
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);

        // 4: SOF on the 7th pixel restarts the frame
        fd_at.delete();
        for (int i = 0; i < 6; i++) cyc(1'b1, i == 0, 1'b1);
        for (int i = 0; i < W * H; i++) cyc(1'b1, i == 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t4_frame_done_count", fd_at.size(), 1);

        // 5: asynchronous reset after 9 accepts, then a pixel without SOF
        for (int i = 0; i < 9; i++) cyc(1'b1, i == 0, 1'b1);
        reset_async();
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // 6: back-to-back frames
        fd_at.delete();
        dut_cons = 0;
        for (int i = 0; i < 2 * W * H; i++) cyc(1'b1, (i % (W * H)) == 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t6_frame_done_count", fd_at.size(), 2);
        if (fd_at.size() == 2) chk("t6_frame_gap", fd_at[1] - fd_at[0], W * H);
        chk("t6_window_count", dut_cons, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
